// File: rtl/jtag_scan_sequencer.sv
// JTAG host sequencer: runs TAP reset, IR/DR scans and idle clocks on tck/tms/tdi
// and captures tdo_in into a one-cycle response.
//
// Ports:
//   clk, reset (async, active low)
//   cmd_valid/cmd_ready, cmd_op, cmd_len, cmd_data : command handshake
//   rsp_valid, rsp_data                            : response pulse and data
//   busy                                           : a sequence is running
//   tck, tms, tdi, tdo_in                          : JTAG port
//
// Optional macro JTAG_TCK_DIV_EN: each tck phase lasts HALF_PERIOD clk cycles.
// Without it every phase is one clk cycle.
module jtag_scan_sequencer #(
    parameter int IR_WIDTH    = 2,
    parameter int DR_MAX      = 8,
    parameter int LEN_W       = 4,
    parameter int HALF_PERIOD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              busy,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo_in
);

    localparam int CW0   = (LEN_W > 3) ? LEN_W : 3;
    localparam int CW1   = ($clog2(DR_MAX + 1) > CW0) ? $clog2(DR_MAX + 1) : CW0;
    localparam int CNT_W = ($clog2(IR_WIDTH + 1) > CW1) ? $clog2(IR_WIDTH + 1) : CW1;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(DR_MAX);
    localparam logic [CNT_W-1:0] IR_N  = CNT_W'(IR_WIDTH);

    localparam logic [1:0] OP_RST  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_DR   = 2'b10;
    localparam logic [1:0] OP_IDLE = 2'b11;

    typedef enum logic [2:0] {
        IDLE, TLR, SEL, CAP, SHIFT, EXIT_UPD, RUN, RESP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  nbits;
    logic [CNT_W-1:0]  run_n;
    logic [1:0]        op;
    logic [DR_MAX-1:0] sdata;
    logic [DR_MAX-1:0] cap;
    logic              auto_rst;
    logic              tick;

    logic [CNT_W-1:0] len_ext;
    logic [CNT_W-1:0] dr_n;
    logic [CNT_W-1:0] sel_last;

    assign len_ext  = CNT_W'(cmd_len);
    // DR goes straight from Select-DR to Capture; IR needs one more Select.
    assign sel_last = (op == OP_IR) ? ONE : '0;

    always_comb begin
        dr_n = len_ext;
        if (len_ext == '0) begin
            dr_n = ONE;
        end else if (len_ext > MAX_N) begin
            dr_n = MAX_N;
        end
    end

`ifdef JTAG_TCK_DIV_EN
    localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

    logic [DIV_W-1:0] div_cnt;

    // Held at reload while waiting so every sequence starts a full phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= DIV_LAST;
        end else if (state == IDLE || state == RESP || div_cnt == '0) begin
            div_cnt <= DIV_LAST;
        end else begin
            div_cnt <= div_cnt - DIV_W'(1);
        end
    end

    assign tick = (div_cnt == '0);
`else
    logic unused_hp;
    assign unused_hp = (HALF_PERIOD > 0);
    assign tick      = 1'b1;
`endif

    // A tick with tck low raises tck (and samples tdo); a tick with tck high
    // drops tck and sets tms/tdi for the next period or finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= TLR;
            cnt       <= '0;
            nbits     <= ONE;
            run_n     <= ONE;
            op        <= OP_RST;
            sdata     <= '0;
            cap       <= '0;
            auto_rst  <= 1'b1;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op        <= cmd_op;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        cap       <= '0;
                        sdata     <= cmd_data;
                        cnt       <= '0;
                        tdi       <= 1'b0;
                        run_n     <= ONE;
                        unique case (cmd_op)
                            OP_RST: begin
                                state <= TLR;
                                tms   <= 1'b1;
                            end
                            OP_IR: begin
                                state <= SEL;
                                tms   <= 1'b1;
                                nbits <= IR_N;
                            end
                            OP_DR: begin
                                state <= SEL;
                                tms   <= 1'b1;
                                nbits <= dr_n;
                            end
                            OP_IDLE: begin
                                if (len_ext == '0) begin
                                    state     <= RESP;
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= '0;
                                end else begin
                                    state <= RUN;
                                    tms   <= 1'b0;
                                    run_n <= len_ext;
                                end
                            end
                        endcase
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    if (tick && !tck) begin
                        tck <= 1'b1;
                        if (state == SHIFT) begin
                            for (int i = 0; i < DR_MAX; i++) begin
                                if (cnt == CNT_W'(i)) begin
                                    cap[i] <= tdo_in;
                                end
                            end
                        end
                    end else if (tick) begin
                        tck <= 1'b0;
                        case (state)
                            TLR: begin
                                if (cnt == CNT_W'(4)) begin
                                    state <= RUN;
                                    cnt   <= '0;
                                    tms   <= 1'b0;
                                end else begin
                                    cnt <= cnt + ONE;
                                    tms <= 1'b1;
                                end
                            end
                            SEL: begin
                                if (cnt == sel_last) begin
                                    state <= CAP;
                                    cnt   <= '0;
                                    tms   <= 1'b0;
                                end else begin
                                    cnt <= cnt + ONE;
                                    tms <= 1'b1;
                                end
                            end
                            CAP: begin
                                if (cnt == ONE) begin
                                    state <= SHIFT;
                                    cnt   <= '0;
                                    tms   <= (nbits == ONE);
                                    tdi   <= sdata[0];
                                    sdata <= sdata >> 1;
                                end else begin
                                    cnt <= cnt + ONE;
                                    tms <= 1'b0;
                                end
                            end
                            SHIFT: begin
                                if (cnt == nbits - ONE) begin
                                    state <= EXIT_UPD;
                                    cnt   <= '0;
                                    tms   <= 1'b1;
                                    tdi   <= 1'b0;
                                end else begin
                                    cnt   <= cnt + ONE;
                                    tms   <= ((cnt + ONE) == (nbits - ONE));
                                    tdi   <= sdata[0];
                                    sdata <= sdata >> 1;
                                end
                            end
                            EXIT_UPD: begin
                                state <= RUN;
                                cnt   <= '0;
                                tms   <= 1'b0;
                            end
                            RUN: begin
                                if (cnt == run_n - ONE) begin
                                    cnt <= '0;
                                    if (auto_rst) begin
                                        state     <= IDLE;
                                        auto_rst  <= 1'b0;
                                        cmd_ready <= 1'b1;
                                        busy      <= 1'b0;
                                    end else begin
                                        state     <= RESP;
                                        rsp_valid <= 1'b1;
                                        rsp_data  <= cap;
                                    end
                                end else begin
                                    cnt <= cnt + ONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/jtag_scan_sequencer.md
Name: jtag_scan_sequencer

Overview:
Host-side JTAG master that drives tck/tms/tdi into the TAP and scan paths, and captures tdo.
- Accepts one command at a time over a valid/ready handshake: TAP reset, IR scan, DR scan or idle cycles.
- Walks the TAP state machine with the correct TMS sequence for each command.
- Returns the captured TDO bits as a one-cycle response.
- Sits between the test/config logic and the JTAG port of the chip top.

Parameters:
IR_WIDTH, 2, instruction register length in bits (IR scans always shift exactly this many bits)
DR_MAX, 8, maximum DR scan length and width of the data buses
LEN_W, 4, width of cmd_len
HALF_PERIOD, 2, clk cycles per tck phase; used only when JTAG_TCK_DIV_EN is defined

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00 TAP reset, 01 IR scan, 10 DR scan, 11 idle
cmd_len  input  LEN_W  DR bit count, or idle tck count
cmd_data  input  DR_MAX  TDI bits, LSB shifted first
rsp_valid  output  1  one-cycle pulse when a command completes
rsp_data  output  DR_MAX  captured TDO bits
busy  output  1  high while any sequence is running
tck  output  1  JTAG clock
tms  output  1  JTAG mode select
tdi  output  1  JTAG data to target
tdo_in  input  1  JTAG data from target

Behaviour:
Reset values
- tck=0, tms=1, tdi=0, rsp_valid=0, rsp_data=0, cmd_ready=0, busy=1.
- On reset release, the block runs the TAP-reset sequence automatically, then goes IDLE with cmd_ready=1 and busy=0.
- No rsp_valid pulse is generated for this automatic sequence.

tck timing
- One tck period = phase LOW (tck=0) then phase HIGH (tck=1).
- Each phase lasts 1 clk cycle, or HALF_PERIOD cycles with the optional feature.
- tms and tdi change only at the start of phase LOW.
- tdo_in is sampled on the clk edge that drives tck 0->1.

Handshake
- A command is accepted when cmd_valid && cmd_ready.
- cmd_op, cmd_len and cmd_data are latched on acceptance.
- cmd_ready=0 from the acceptance cycle until the cycle after rsp_valid.

FSM states: IDLE, TLR, SEL, CAP, SHIFT, EXIT_UPD, RUN, RESP.
- TAP reset (00): 5 tcks with tms=1, then 1 tck with tms=0; ends in Run-Test/Idle. rsp_data=0.
- IR scan (01) tms sequence, starting from Run-Test/Idle:
  - 1, 1, 0, 0;
  - IR_WIDTH shift tcks, tms=0 on all but the last, tms=1 on the last;
  - then 1, 0.
- DR scan (10): same as IR scan but with a single leading 1 before 0, 0; shifts N bits.
- Shift data:
  - tdi during shift bit i is cmd_data[i].
  - The TDO sample at shift bit i is stored in rsp_data[i].
  - Bits above the shift length are 0.
- DR length rules: N = cmd_len; cmd_len=0 is treated as 1; cmd_len>DR_MAX is clamped to DR_MAX.
- Idle (11): cmd_len tcks with tms=0. cmd_len=0 produces no tck and the response is issued the cycle after acceptance. rsp_data=0.
- After the last tck of any command the FSM enters RESP: rsp_valid=1 for exactly one cycle, rsp_data held until the next response.
- tdi=0 outside shift bits; tck stays 0 in IDLE; tms stays at its last value (0) in IDLE.
- Asserting reset mid-command aborts immediately: outputs return to reset values, no response is issued, and the automatic TAP-reset sequence restarts.
- cmd_valid while busy is ignored (not queued).

Optional Feature:
Macro JTAG_TCK_DIV_EN.
- Defined: each tck phase lasts HALF_PERIOD clk cycles, using a phase counter that reloads at each phase edge. HALF_PERIOD=1 behaves identically to undefined.
- Undefined: 1 clk per phase (tck = clk/2); the counter logic and the HALF_PERIOD parameter are unused.

Test Plan:
1. Reset release, feature undefined:
   - Required: exactly 6 tck rising edges with tms=1,1,1,1,1,0; then cmd_ready=1 after 12 clk; no rsp_valid.
2. IR scan cmd_data=2'b11 against the chip top (IR captures 2'b01):
   - Required: 8 tcks with tms=1,1,0,0,0,1,1,0; tdi=1,1 on the shift bits; rsp_data=8'h01; single rsp_valid pulse.
3. After loading bypass (IR=2'b11), DR scan cmd_len=4, cmd_data=8'h0B:
   - Required: rsp_data=8'h06 (one-bit bypass delay, capture bit 0).
4. DR scan cmd_len=12 and cmd_len=0:
   - Required: 8 shift tcks and 1 shift tck respectively; upper rsp_data bits 0.
5. Idle cmd_len=3, then idle cmd_len=0:
   - Required: 3 tcks with tms=0, then a rsp_valid pulse with no tck for the second command; cmd_valid held during busy produces no extra command.
6. Reset asserted during shift bit 2 of a DR scan:
   - Required: tck=0 and tms=1 immediately; no rsp_valid; the TAP-reset sequence reruns after release.
   - Repeat test 2 with JTAG_TCK_DIV_EN and HALF_PERIOD=3: each tck phase is 3 clk long; same rsp_data.
